adc_wave_capture: RTL and testbench
===================================

// Module: adc_wave_capture
// PURPOSE
//  Threshold-triggered ADC waveform capture buffer.
//  - Records DEPTH consecutive ADC samples into on-chip RAM after a rising threshold crossing.
//  - Presents them one at a time on a 16-bit word that drives the waveSample PIO in_port.
//  - Software arms capture, polls status bits, and steps through samples via a PIO output strobe.
// PARAMETERS
//  DATA_W    14    ADC sample width, unsigned; must be <= 14
//  DEPTH     1024  samples per capture; power of two, >= 4
//  ADDR_W    10    log2(DEPTH)
// PORTS
//  clk          in   1       system clock; ADC data already synchronous to clk
//  reset_n      in   1       asynchronous, active-low reset
//  adc_valid    in   1       adc_data qualifier, one sample per asserted cycle
//  adc_data     in   DATA_W  unsigned ADC sample
//  threshold    in   DATA_W  trigger level, unsigned; static while ARMED
//  arm          in   1       level from PIO; rising edge arms a capture
//  rd_next      in   1       level from PIO; rising edge advances readout
//  wave_sample  out  16      {valid, last, zero-extended sample}; feeds PIO in_port
//  busy         out  1       high in ARMED or CAPTURE
//  rd_idx       out  ADDR_W  index of the sample currently on wave_sample
// BEHAVIOUR
//  - Edge detect: arm and rd_next are each registered once; edge = cur & ~prev.
//  - Outputs are registered. Reset values: wave_sample=0, busy=0, rd_idx=0, state=IDLE.
//  - RAM contents are not cleared by reset.
//  - FSM states: IDLE, ARMED, CAPTURE, READOUT.
//  - IDLE: wave_sample=0. Arm edge -> ARMED; clear wr_ptr and the prev-sample register.
//  - ARMED: trigger on adc_valid && adc_data>=threshold && prev_valid_sample<threshold.
//    - prev_valid_sample is forced to all-ones on entry, so a signal already above threshold at arm does not trigger.
//    - The trigger sample is written at address 0; then -> CAPTURE, with wr_ptr=1.
//  - CAPTURE: each adc_valid writes adc_data at wr_ptr, then wr_ptr++.
//    - When the write at DEPTH-1 completes -> READOUT with rd_ptr=0.
//    - adc_valid gaps stall capture; no sample is skipped or duplicated.
//  - READOUT: RAM read latency is 1 cycle; wave_sample is registered after the RAM.
//    - Sample N appears on wave_sample 2 cycles after rd_ptr becomes N.
//    - wave_sample = {1'b1, (rd_ptr==DEPTH-1), {(14-DATA_W){0}}, data}; rd_idx = rd_ptr.
//    - rd_next edge with rd_ptr<DEPTH-1: rd_ptr++.
//    - rd_next edge with rd_ptr==DEPTH-1: -> IDLE; wave_sample=0 on the next cycle.
//  - Software rule: wait >= 3 clk after a rd_next edge before reading (PIO adds 1 cycle).
//  - Arm edge in CAPTURE: ignored. Arm edge in ARMED: ignored (stays armed).
//  - Arm edge in READOUT: abort readout -> ARMED; wave_sample=0 next cycle.
//  - Arm edge and rd_next edge in the same cycle in READOUT: arm wins.
//  - rd_next edges in IDLE, ARMED or CAPTURE: no effect.
//  - busy = (state==ARMED)||(state==CAPTURE), registered with state.
//  - Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values.
// CONFIGURATION
//  WAVE_CAPTURE_FORCE_TRIG_EN defined:
//    - Adds input port force_trig (1 bit, level, edge-detected like arm).
//    - A force_trig edge in ARMED triggers regardless of threshold.
//    - The first sample is the next adc_valid sample (the same cycle if adc_valid is high).
//    - Ignored in all other states.
//  Not defined: force_trig port and logic absent; threshold crossing is the only trigger.
// TESTING  (bench uses DEPTH=8, ADDR_W=3, DATA_W=14)
//  - Reset: reset_n=0 mid-CAPTURE -> wave_sample=0, busy=0, rd_idx=0 immediately; after release, IDLE.
//  - Basic capture: threshold=100, arm edge, ramp adc_data 90,95,..,140 every cycle -> first stored sample 100.
//    - Reading 8 times gives 100..135; last read wave_sample=16'hC000|135, earlier reads 16'h8000|data.
//  - No false trigger: adc_data held at 200 before and after arm, threshold=100 -> stays ARMED, busy=1.
//    - Then a drop to 50 followed by 150 -> triggers on 150.
//  - Gapped valid: adc_valid every 3rd cycle during CAPTURE -> 8 consecutive valid samples stored, none skipped.
//  - Readout boundary: after 8th rd_next edge -> IDLE, wave_sample=0.
//    - A 9th rd_next edge leaves state IDLE with wave_sample=0.
//  - Abort: arm edge together with rd_next edge at rd_idx=3 -> ARMED, wave_sample=0, busy=1, rd_idx=0.
//  - FORCE_TRIG_EN build: threshold=16383, adc_data constant 42, force_trig edge -> capture 8x42.
//    - wave_sample reads 16'h802A (last read 16'hC02A).

Source files
------------

// File: rtl/adc_wave_capture.sv
// adc_wave_capture
//   Threshold-triggered ADC waveform capture buffer. After software arms it,
//   the block waits for a rising crossing of `threshold`. It then records DEPTH
//   consecutive valid ADC samples into on-chip RAM. Software steps through
//   the samples one at a time on a 16-bit PIO word.
//
// Ports
//   clk          system clock (ADC data already synchronous)
//   reset_n      asynchronous, active-low reset
//   adc_valid    qualifies adc_data, one sample per asserted cycle
//   adc_data     unsigned ADC sample [DATA_W]
//   threshold    unsigned trigger level [DATA_W], static while armed
//   arm          PIO level; rising edge arms (or aborts a readout and re-arms)
//   rd_next      PIO level; rising edge advances readout
//   force_trig   PIO level; rising edge while armed triggers unconditionally
//                (present only when WAVE_CAPTURE_FORCE_TRIG_EN is defined)
//   wave_sample  {valid, last, zero-extended sample}, registered
//   busy         high while armed or capturing, registered
//   rd_idx       index of the sample being presented
//
// Optional build macro: WAVE_CAPTURE_FORCE_TRIG_EN

module adc_wave_capture #(
  parameter int DATA_W = 14,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  input  logic [DATA_W-1:0] threshold,
  input  logic              arm,
  input  logic              rd_next,
`ifdef WAVE_CAPTURE_FORCE_TRIG_EN
  input  logic              force_trig,
`endif
  output logic [15:0]       wave_sample,
  output logic              busy,
  output logic [ADDR_W-1:0] rd_idx
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, READOUT} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic              arm_q, rd_next_q;
  logic              arm_edge, rd_edge;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [ADDR_W-1:0] rd_ptr, rd_ptr_nxt;
  logic [DATA_W-1:0] prev_sample, prev_sample_nxt;
  logic              busy_nxt;
  logic [15:0]       wave_nxt;
  logic              crossing, trig;
  logic              mem_we;
  logic [13:0]       sample14;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q;
  logic              last_q;
  logic              q_vld;

`ifdef WAVE_CAPTURE_FORCE_TRIG_EN
  logic force_q, force_pend, force_pend_nxt, force_hit;
  // A force edge with no sample that cycle is held until the next valid sample.
  assign force_hit      = (force_trig & ~force_q) | force_pend;
  assign force_pend_nxt = (state == ARMED) && force_hit && !adc_valid;
`else
  logic force_hit;
  assign force_hit = 1'b0;
`endif

  assign arm_edge = arm & ~arm_q;
  assign rd_edge  = rd_next & ~rd_next_q;
  assign crossing = (adc_data >= threshold) && (prev_sample < threshold);
  assign trig     = adc_valid && (crossing || force_hit);
  assign rd_idx   = rd_ptr;

  always_comb begin
    state_nxt       = state;
    wr_ptr_nxt      = wr_ptr;
    rd_ptr_nxt      = rd_ptr;
    prev_sample_nxt = prev_sample;
    mem_we          = 1'b0;
    case (state)
      IDLE: begin
        if (arm_edge) begin
          state_nxt       = ARMED;
          wr_ptr_nxt      = '0;
          prev_sample_nxt = '1;
        end
      end
      ARMED: begin
        if (trig) begin
          mem_we     = 1'b1;
          wr_ptr_nxt = ADDR_W'(1);
          state_nxt  = CAPTURE;
        end else if (adc_valid) begin
          prev_sample_nxt = adc_data;
        end
      end
      CAPTURE: begin
        if (adc_valid) begin
          mem_we = 1'b1;
          if (wr_ptr == LAST) begin
            state_nxt  = READOUT;
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
          end else begin
            wr_ptr_nxt = wr_ptr + 1'b1;
          end
        end
      end
      READOUT: begin
        if (arm_edge) begin
          state_nxt       = ARMED;
          wr_ptr_nxt      = '0;
          rd_ptr_nxt      = '0;
          prev_sample_nxt = '1;
        end else if (rd_edge) begin
          if (rd_ptr == LAST) begin
            state_nxt  = IDLE;
            rd_ptr_nxt = '0;
          end else begin
            rd_ptr_nxt = rd_ptr + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == ARMED) || (state_nxt == CAPTURE);

    sample14               = '0;
    sample14[DATA_W-1:0]   = ram_q;
    // Leaving READOUT blanks the word on the very next cycle, even though the
    // read pipeline still holds a sample.
    if ((state_nxt == READOUT) && q_vld)
      wave_nxt = {1'b1, last_q, sample14};
    else
      wave_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      arm_q       <= 1'b0;
      rd_next_q   <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      prev_sample <= '1;
      busy        <= 1'b0;
      wave_sample <= '0;
      last_q      <= 1'b0;
      q_vld       <= 1'b0;
    end else begin
      state       <= state_nxt;
      arm_q       <= arm;
      rd_next_q   <= rd_next;
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      prev_sample <= prev_sample_nxt;
      busy        <= busy_nxt;
      wave_sample <= wave_nxt;
      last_q      <= (rd_ptr == LAST);
      q_vld       <= (state_nxt == READOUT);
    end
  end

`ifdef WAVE_CAPTURE_FORCE_TRIG_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      force_q    <= 1'b0;
      force_pend <= 1'b0;
    end else begin
      force_q    <= force_trig;
      force_pend <= force_pend_nxt;
    end
  end
`endif

  // Capture RAM: contents survive reset; one-cycle registered read.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[wr_ptr] <= adc_data;
    ram_q <= mem[rd_ptr];
  end

endmodule

// File: tb/tb_adc_wave_capture.sv
module tb_adc_wave_capture;

  localparam int DATA_W = 14;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              adc_valid = 1'b0;
  logic [DATA_W-1:0] adc_data = '0;
  logic [DATA_W-1:0] threshold = '0;
  logic              arm = 1'b0;
  logic              rd_next = 1'b0;
`ifdef WAVE_CAPTURE_FORCE_TRIG_EN
  logic              force_trig = 1'b0;
`endif
  logic [15:0]       wave_sample;
  logic              busy;
  logic [ADDR_W-1:0] rd_idx;

  int errors = 0;
  int checks = 0;

  bit          qv[$];
  logic [13:0] qd[$];
  logic [13:0] exp_mem [DEPTH];

  always #5 clk = ~clk;

  adc_wave_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .adc_valid  (adc_valid),
    .adc_data   (adc_data),
    .threshold  (threshold),
    .arm        (arm),
    .rd_next    (rd_next),
`ifdef WAVE_CAPTURE_FORCE_TRIG_EN
    .force_trig (force_trig),
`endif
    .wave_sample(wave_sample),
    .busy       (busy),
    .rd_idx     (rd_idx)
  );

  // Reference: scan everything the DUT saw while armed, find the first rising
  // crossing among valid samples, and take that plus the next DEPTH-1 valid ones.
  function automatic bit model_capture(input logic [13:0] thr);
    logic [13:0] prev;
    int n;
    bit trg;
    prev = '1;
    n = 0;
    trg = 0;
    foreach (qv[i]) begin
      if (qv[i]) begin
        if (!trg) begin
          if (qd[i] >= thr && prev < thr) begin
            trg = 1;
            exp_mem[0] = qd[i];
            n = 1;
          end else begin
            prev = qd[i];
          end
        end else if (n < DEPTH) begin
          exp_mem[n] = qd[i];
          n++;
        end
      end
    end
    return n == DEPTH;
  endfunction

  task automatic reset_dut();
    reset_n = 1'b0;
    arm = 1'b0;
    rd_next = 1'b0;
    adc_valid = 1'b0;
`ifdef WAVE_CAPTURE_FORCE_TRIG_EN
    force_trig = 1'b0;
`endif
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic arm_pulse();
    @(negedge clk) arm = 1'b1;
    @(negedge clk) arm = 1'b0;
  endtask

  task automatic rd_pulse();
    @(negedge clk) rd_next = 1'b1;
    @(negedge clk) rd_next = 1'b0;
  endtask

  // Drives samples until busy drops (capture complete) or budget expires.
  task automatic run_capture(input int mode, input int maxcyc, output bit ok);
    bit v;
    logic [13:0] d;
    qv.delete();
    qd.delete();
    ok = 0;
    for (int i = 0; i < maxcyc; i++) begin
      if (!busy) begin
        ok = 1;
        break;
      end
      case (mode)
        0: begin v = 1; d = 14'(90 + 5 * i); end
        1: begin v = 1; d = (i == 0) ? 14'd50 : 14'(150 + i - 1); end
        2: begin
          v = (i % 3 == 0);
          if (v) d = (i < 6) ? 14'(20 + i) : 14'(100 + i);
          else   d = 14'($urandom_range(0, 16383));
        end
        default: begin
          v = ($urandom_range(0, 3) != 0);
          d = 14'($urandom_range(0, 16383));
        end
      endcase
      adc_valid = v;
      adc_data  = d;
      qv.push_back(v);
      qd.push_back(d);
      @(negedge clk);
    end
    adc_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL capture_done mode=%0d busy=%b required=0 within %0d cycles", mode, busy, maxcyc);
      reset_dut();
    end
  endtask

  // Steps through all samples, then checks the exit to IDLE and a spare rd_next.
  task automatic check_readout(input string tag, input bit use_model);
    logic [15:0] exp;
    if (use_model) begin
      checks++;
      if (!model_capture(threshold)) begin
        errors++;
        $display("FAIL %s_model no complete capture in stimulus", tag);
        return;
      end
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      exp = {1'b1, (i == DEPTH - 1), exp_mem[i]};
      checks++;
      if (wave_sample !== exp || rd_idx !== ADDR_W'(i)) begin
        errors++;
        $display("FAIL %s_read[%0d] wave=%h idx=%0d required wave=%h idx=%0d",
                 tag, i, wave_sample, rd_idx, exp, i);
      end
      rd_pulse();
      if (i < DEPTH - 1) repeat (2) @(negedge clk);
    end
    checks++;
    if (wave_sample !== 16'h0 || busy !== 1'b0 || rd_idx !== '0) begin
      errors++;
      $display("FAIL %s_exit wave=%h busy=%b idx=%0d required 0/0/0", tag, wave_sample, busy, rd_idx);
    end
    rd_pulse();
    repeat (2) @(negedge clk);
    checks++;
    if (wave_sample !== 16'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_extra_rd wave=%h busy=%b required 0/0", tag, wave_sample, busy);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (wave_sample !== 16'h0 || busy !== 1'b0 || rd_idx !== '0) begin
      errors++;
      $display("FAIL reset_values wave=%h busy=%b idx=%0d required 0/0/0", wave_sample, busy, rd_idx);
    end
    reset_n = 1'b1;
    threshold = 14'd100;
    arm_pulse();
    for (int i = 0; i < 5; i++) begin
      adc_valid = 1'b1;
      adc_data = 14'(90 + 5 * i);
      @(negedge clk);
    end
    adc_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_precapture busy=%b required 1", busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (wave_sample !== 16'h0 || busy !== 1'b0 || rd_idx !== '0) begin
      errors++;
      $display("FAIL reset_async wave=%h busy=%b idx=%0d required 0/0/0", wave_sample, busy, rd_idx);
    end
    @(negedge clk);
    reset_n = 1'b1;
    rd_pulse();
    repeat (3) @(negedge clk);
    checks++;
    if (wave_sample !== 16'h0 || busy !== 1'b0 || rd_idx !== '0) begin
      errors++;
      $display("FAIL reset_idle wave=%h busy=%b idx=%0d required 0/0/0", wave_sample, busy, rd_idx);
    end
  endtask

  task automatic test_basic();
    bit ok;
    threshold = 14'd100;
    arm_pulse();
    run_capture(0, 100, ok);
    if (ok) check_readout("basic", 1);
  endtask

  task automatic test_no_false_trigger();
    bit ok;
    threshold = 14'd100;
    adc_valid = 1'b1;
    adc_data = 14'd200;
    repeat (3) @(negedge clk);
    arm_pulse();
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL no_false_trig busy=%b required 1", busy);
    end
    run_capture(1, 100, ok);
    if (ok) check_readout("cross_after_drop", 1);
  endtask

  task automatic test_gapped_valid();
    bit ok;
    threshold = 14'd100;
    arm_pulse();
    run_capture(2, 200, ok);
    if (ok) check_readout("gapped", 1);
  endtask

  task automatic test_abort();
    bit ok;
    threshold = 14'd100;
    arm_pulse();
    run_capture(0, 100, ok);
    if (!ok) return;
    repeat (2) @(negedge clk);
    repeat (3) rd_pulse();
    repeat (2) @(negedge clk);
    checks++;
    if (rd_idx !== 3'd3 || wave_sample[15] !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre idx=%0d valid=%b required 3/1", rd_idx, wave_sample[15]);
    end
    @(negedge clk);
    arm = 1'b1;
    rd_next = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    rd_next = 1'b0;
    checks++;
    if (busy !== 1'b1 || wave_sample !== 16'h0 || rd_idx !== '0) begin
      errors++;
      $display("FAIL abort busy=%b wave=%h idx=%0d required 1/0000/0", busy, wave_sample, rd_idx);
    end
    run_capture(3, 400, ok);
    if (ok) check_readout("after_abort", 1);
  endtask

  task automatic test_random();
    bit ok;
    for (int t = 0; t < 4; t++) begin
      threshold = 14'($urandom_range(2000, 14000));
      arm_pulse();
      run_capture(3, 400, ok);
      if (ok) check_readout("random", 1);
    end
  endtask

`ifdef WAVE_CAPTURE_FORCE_TRIG_EN
  task automatic test_force_trig();
    bit done;
    threshold = 14'd16383;
    adc_valid = 1'b1;
    adc_data = 14'd42;
    arm_pulse();
    @(negedge clk) force_trig = 1'b1;
    @(negedge clk) force_trig = 1'b0;
    done = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) begin
        done = 1;
        break;
      end
      @(negedge clk);
    end
    adc_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL force_done busy=%b required 0", busy);
      reset_dut();
      return;
    end
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 14'd42;
    check_readout("force", 0);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_no_false_trigger();
    test_gapped_valid();
    test_abort();
    test_random();
`ifdef WAVE_CAPTURE_FORCE_TRIG_EN
    test_force_trig();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
